// File: rtl/phase_follow_pkg.sv
// Shared definitions for the phase-follow generator: channel FSM states and
// default sizing.
package phase_follow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2
    } pfg_state_t;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 8;

endpackage

// File: rtl/phase_follow_gen_channel.sv
// One phase-follow channel: follows src through a WAIT0/WAIT1 phase pair,
// free-running or re-armed by a change of src.
module pfg_channel
    import phase_follow_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_i,
    input  logic          en_i,
    input  logic          src_i,
    input  logic [CW-1:0] ph0_len_i,
    input  logic [CW-1:0] ph1_len_i,
    output logic          out_o,
    output logic          busy_o
);

    pfg_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          out_q;
    logic          src_q;
    logic          change_d;

    // A zero length behaves like one cycle, so the reload value is never negative.
    function automatic logic [CW-1:0] reload(input logic [CW-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    assign change_d = (src_i != src_q);
    assign out_o    = out_q;
    assign busy_o   = (state_q == WAIT0) || (state_q == WAIT1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            src_q   <= src_i;
        end else begin
            src_q <= src_i;
            if (!en_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!mode_i || change_d) begin
                            state_q <= WAIT0;
                            cnt_q   <= reload(ph0_len_i);
                        end
                    end
                    WAIT0: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            out_q   <= src_q;
                            state_q <= WAIT1;
                            cnt_q   <= reload(ph1_len_i);
                        end
                    end
                    WAIT1: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            out_q <= ~src_q;
                            // Mode is only consulted here, at the end of a full cycle.
                            if (mode_i) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= WAIT0;
                                cnt_q   <= reload(ph0_len_i);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/phase_follow_gen.sv
// Multi-channel phase-follow generator: fans shared controls out to NCH
// independent channels.
module phase_follow_gen
    import phase_follow_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [NCH-1:0] en,
    input  logic [NCH-1:0] src,
    input  logic [CW-1:0]  ph0_len,
    input  logic [CW-1:0]  ph1_len,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] busy
);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            pfg_channel #(
                .CW(CW)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .mode_i    (mode),
                .en_i      (en[gi]),
                .src_i     (src[gi]),
                .ph0_len_i (ph0_len),
                .ph1_len_i (ph1_len),
                .out_o     (out[gi]),
                .busy_o    (busy[gi])
            );
        end
    endgenerate

endmodule

// File: doc/phase_follow_gen.md
PHASE_FOLLOW_GEN -- requirements
Module: phase_follow_gen

Interface
REQ-001 Parameter NCH, default 4: number of independent channels.
REQ-002 Parameter CW, default 8: phase-length counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mode  input  1  0 = free-running, 1 = triggered (re-arm on src change).
REQ-006 en  input  NCH  per-channel enable.
REQ-007 src  input  NCH  per-channel source value to be followed.
REQ-008 ph0_len  input  CW  WAIT0 length in cycles, shared by all channels.
REQ-009 ph1_len  input  CW  WAIT1 length in cycles, shared by all channels.
REQ-010 out  output  NCH  per-channel generated waveform, registered.
REQ-011 busy  output  NCH  per-channel flag, high while the channel is in WAIT0 or WAIT1.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, WAIT0 and WAIT1, plus a CW-bit down-counter cnt and a registered copy src_q of src.
REQ-013 src_q SHALL load src every cycle; a channel change event SHALL be src != src_q.
REQ-014 On entry to WAIT0 or WAIT1, cnt SHALL load len-1 from the current ph0_len or ph1_len; a len of 0 SHALL be treated as 1.
REQ-015 In any WAITx state with cnt != 0, the channel SHALL decrement cnt and hold out.
REQ-016 In WAIT0 with cnt == 0, the channel SHALL set out <= src_q and enter WAIT1.
REQ-017 In WAIT1 with cnt == 0, the channel SHALL set out <= ~src_q, then enter WAIT0 if mode == 0, or IDLE if mode == 1.
REQ-018 In IDLE with en = 1, the channel SHALL enter WAIT0 on the next edge if mode == 0, or on the edge where a change event is seen if mode == 1.
REQ-019 In triggered mode, change events during WAIT0 or WAIT1 SHALL be ignored, with no queuing.
REQ-020 en low in any state SHALL force IDLE on the next edge; out holds its last value.
REQ-021 A mode change mid-sequence SHALL take effect only at the WAIT1 exit decision.
REQ-022 Phase lengths SHALL be sampled only at phase entry; changing them mid-phase does not affect the running count.
REQ-023 Free-mode output period SHALL be max(ph0_len,1) + max(ph1_len,1) cycles.
REQ-024 Channels SHALL never interact, including when events occur in the same cycle.

Reset
REQ-025 While rst = 1: state = IDLE, cnt = 0, out = 0, busy = 0, src_q <= src, so no change event fires at reset release.
REQ-026 Reset asserted mid-sequence SHALL abort it on that edge; there is no partial output update.

Structure
REQ-027 Shared package phase_follow_pkg SHALL hold the state enum (IDLE, WAIT0, WAIT1) and the default values of NCH and CW.
REQ-028 Per-channel logic SHALL live in sub-module pfg_channel, instantiated NCH times by a generate loop; the top level only fans out shared inputs.

Verification
Cycle n = nth rising edge with rst = 0.
REQ-029 Free run: mode=0, en=1, src=1, ph0=ph1=2 -> IDLE->WAIT0 at edge 1; out=1 after edge 3, 0 after edge 5, 1 after edge 7; period 4, busy=1 from edge 1.
REQ-030 Triggered: mode=1, en=1, src 0->1 at cycle 10, ph0=1, ph1=3 -> WAIT0 at edge 11, out=1 after edge 12, out=0 after edge 15, IDLE at edge 15, no further activity.
REQ-031 Ignored event: as REQ-030, with src toggling again at cycle 13 -> no retrigger after edge 15; out stays ~src_q as sampled at edge 15.
REQ-032 Zero length: ph0=0, ph1=0, mode=0 -> out toggles every cycle (period 2).
REQ-033 Disable and reset mid-op: en drops during WAIT1 -> IDLE next edge, out held; rst pulsed during WAIT0 -> out=0, busy=0 next edge, no spurious trigger after release with src=1.
REQ-034 Channel independence: NCH=4, mixed en and src patterns -> each channel matches a single-channel reference model cycle-for-cycle.
